// File: rtl/riscv_rf_pkg.sv
// riscv_rf_pkg: shared widths, writeback source ids and register-zero index for the register file.
package riscv_rf_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W = 2;
  localparam int REG_ZERO = 0;
  typedef enum logic {WB_ALU, WB_MEM} wb_src_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: writeback sources, register-file write port and issue/hazard query bundle.
interface regfile_wb_ctrl_if import riscv_rf_pkg::*; #(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic alu_valid, alu_ready, mem_valid, mem_ready;
  logic [REG_ADDR_W-1:0] alu_rd, mem_rd;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic iss_valid, iss_ready, q_busy1, q_busy2;
  logic [REG_ADDR_W-1:0] iss_rd, q_rs1, q_rs2;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, iss_valid, iss_rd, q_rs1, q_rs2,
    input alu_ready, mem_ready, rf_we, rf_rd, rf_wdata, iss_ready, q_busy1, q_busy2
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, iss_valid, iss_rd, q_rs1, q_rs2,
    output alu_ready, mem_ready, rf_we, rf_rd, rf_wdata, iss_ready, q_busy1, q_busy2
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register saturating outstanding-write counters with issue gating and busy lookup.
module rf_scoreboard import riscv_rf_pkg::*; #(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  output logic                  q_busy1,
  output logic                  q_busy2
);
  localparam int N = 1 << REG_ADDR_W;
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0] inc, hit;
  assign iss_ready = !rst && cnt[iss_rd] != '1;
  assign q_busy1 = cnt[q_rs1] != '0;
  assign q_busy2 = cnt[q_rs2] != '0;
  always_comb begin
    inc = '0;
    hit = '0;
    inc[iss_rd] = iss_valid && iss_ready;
    hit[wb_rd] = wb_valid;
  end
  // simultaneous issue and writeback cancel; a stray writeback at zero clamps instead of wrapping
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (rst || i == REG_ZERO) cnt[i] <= '0;
      else if (inc[i] != hit[i]) cnt[i] <= inc[i] ? cnt[i] + 1'b1 : cnt[i] - CNT_W'(cnt[i] != '0);
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin ALU/MEM writeback arbiter driving registered RF write port.
// Define RF_SCOREBOARD_EN to add per-register outstanding-write tracking for decode hazards.
module regfile_wb_ctrl import riscv_rf_pkg::*; #(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  regfile_wb_ctrl_if.slave bus
);
  wb_src_t last_grant;
  logic alu_gnt, mem_gnt, gnt;
  logic [REG_ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;
  always_comb begin
    alu_gnt = !rst && bus.alu_valid && (!bus.mem_valid || last_grant == WB_MEM);
    mem_gnt = !rst && bus.mem_valid && (!bus.alu_valid || last_grant == WB_ALU);
    gnt = alu_gnt || mem_gnt;
    g_rd = alu_gnt ? bus.alu_rd : bus.mem_rd;
    g_data = alu_gnt ? bus.alu_data : bus.mem_data;
  end
  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  // x0 writes are accepted and advance arbitration but never reach the file
  always_ff @(posedge clk)
    if (rst) begin
      last_grant <= WB_MEM;
      bus.rf_we <= 1'b0;
      bus.rf_rd <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= gnt && g_rd != REG_ADDR_W'(REG_ZERO);
      if (gnt) last_grant <= alu_gnt ? WB_ALU : WB_MEM;
      if (gnt && g_rd != REG_ADDR_W'(REG_ZERO)) begin
        bus.rf_rd <= g_rd;
        bus.rf_wdata <= g_data;
      end
    end
`ifdef RF_SCOREBOARD_EN
  rf_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .iss_valid(bus.iss_valid),
    .iss_rd(bus.iss_rd),
    .iss_ready(bus.iss_ready),
    .wb_valid(gnt),
    .wb_rd(g_rd),
    .q_rs1(bus.q_rs1),
    .q_rs2(bus.q_rs2),
    .q_busy1(bus.q_busy1),
    .q_busy2(bus.q_busy2)
  );
`else
  logic unused_ok;
  assign unused_ok = ^{bus.iss_valid, bus.iss_rd, bus.q_rs1, bus.q_rs2, CNT_W[0]};
  assign bus.iss_ready = 1'b1;
  assign bus.q_busy1 = 1'b0;
  assign bus.q_busy2 = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed and randomized checks of regfile_wb_ctrl against a behavioural model.
module tb_regfile_wb_ctrl;
  import riscv_rf_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_wb_ctrl_if bus ();
  regfile_wb_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  int m_last = 1;
  int m_cnt [32];
  bit m_we;
  logic [4:0] m_rd;
  logic [63:0] m_wd;
  bit g_alu, g_mem;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit av, input int ard, input logic [63:0] ad,
                       input bit mv, input int mrd, input logic [63:0] md);
    bus.alu_valid = av;
    bus.alu_rd = 5'(ard);
    bus.alu_data = ad;
    bus.mem_valid = mv;
    bus.mem_rd = 5'(mrd);
    bus.mem_data = md;
  endtask

  // called at a negedge with inputs already applied; returns at the next negedge
  task automatic cycle();
    bit ir, inc, hit;
    int rd;
    logic [63:0] d;
    #1;
    g_alu = !rst && bus.alu_valid && (!bus.mem_valid || m_last == 1);
    g_mem = !rst && bus.mem_valid && (!bus.alu_valid || m_last == 0);
`ifdef RF_SCOREBOARD_EN
    ir = !rst && m_cnt[bus.iss_rd] != 3;
    check("q_busy1", 64'(bus.q_busy1), 64'(m_cnt[bus.q_rs1] != 0));
    check("q_busy2", 64'(bus.q_busy2), 64'(m_cnt[bus.q_rs2] != 0));
`else
    ir = 1'b1;
    check("q_busy1", 64'(bus.q_busy1), 64'(0));
    check("q_busy2", 64'(bus.q_busy2), 64'(0));
`endif
    check("alu_ready", 64'(bus.alu_ready), 64'(g_alu));
    check("mem_ready", 64'(bus.mem_ready), 64'(g_mem));
    check("iss_ready", 64'(bus.iss_ready), 64'(ir));
    rd = g_alu ? int'(bus.alu_rd) : int'(bus.mem_rd);
    d = g_alu ? bus.alu_data : bus.mem_data;
    @(posedge clk);
    if (rst) begin
      m_last = 1;
      m_we = 1'b0;
      m_rd = '0;
      m_wd = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      m_we = (g_alu || g_mem) && rd != 0;
      if (g_alu || g_mem) m_last = g_alu ? 0 : 1;
      if (m_we) begin
        m_rd = 5'(rd);
        m_wd = d;
      end
`ifdef RF_SCOREBOARD_EN
      inc = bus.iss_valid && ir && bus.iss_rd != 0;
      hit = (g_alu || g_mem) && rd != 0;
      if (inc && !(hit && rd == int'(bus.iss_rd))) m_cnt[bus.iss_rd]++;
      if (hit && !(inc && rd == int'(bus.iss_rd)) && m_cnt[rd] > 0) m_cnt[rd]--;
`else
      inc = 1'b0;
      hit = inc;
`endif
    end
    #1;
    check("rf_we", 64'(bus.rf_we), 64'(m_we));
    check("rf_rd", 64'(bus.rf_rd), 64'(m_rd));
    check("rf_wdata", bus.rf_wdata, m_wd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int seq [4] = '{1, 2, 1, 2};
    bit was_rst;
    drive(0, 0, 0, 0, 0, 0);
    bus.iss_valid = 1'b0;
    bus.iss_rd = '0;
    bus.q_rs1 = '0;
    bus.q_rs2 = '0;
    @(negedge clk);
    do_reset();
    check("rst_rf_we", 64'(bus.rf_we), 64'(0));
    check("rst_rf_rd", 64'(bus.rf_rd), 64'(0));
    check("rst_rf_wdata", bus.rf_wdata, 64'(0));

    drive(1, 5, 64'h1234, 0, 0, 0);
    #1 check("alu_only_ready", 64'(bus.alu_ready), 64'(1));
    cycle();
    check("alu_only_we", 64'(bus.rf_we), 64'(1));
    check("alu_only_rd", 64'(bus.rf_rd), 64'(5));
    check("alu_only_wdata", bus.rf_wdata, 64'h1234);

    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 1, 64'hA1, 1, 2, 64'hB2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("alt_rd", 64'(bus.rf_rd), 64'(seq[i]));
    end

    drive(0, 0, 0, 1, 0, 64'hFF);
    #1 check("x0_mem_ready", 64'(bus.mem_ready), 64'(1));
    cycle();
    check("x0_no_we", 64'(bus.rf_we), 64'(0));
    drive(0, 0, 0, 0, 0, 0);

`ifdef RF_SCOREBOARD_EN
    bus.q_rs1 = 5'd7;
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd7;
    repeat (3) cycle();
    #1 check("sb_busy_after_3", 64'(bus.q_busy1), 64'(1));
    check("sb_sat_ready", 64'(bus.iss_ready), 64'(0));
    cycle();
    bus.iss_valid = 1'b0;
    drive(1, 7, 64'h77, 0, 0, 0);
    repeat (3) cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1 check("sb_busy_drained", 64'(bus.q_busy1), 64'(0));
    bus.q_rs1 = 5'd3;
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd3;
    cycle();
    drive(1, 3, 64'h33, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    bus.iss_valid = 1'b0;
    #1 check("sb_same_cycle_busy", 64'(bus.q_busy1), 64'(1));
    drive(1, 3, 64'h33, 0, 0, 0);
    cycle();
    bus.iss_valid = 1'b1;
    bus.iss_rd = 5'd9;
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    bus.iss_valid = 1'b0;
`endif

    bus.q_rs1 = 5'd9;
    drive(1, 4, 64'h44, 1, 6, 64'h66);
    cycle();
    rst = 1'b1;
    cycle();
    check("rst_conflict_we", 64'(bus.rf_we), 64'(0));
    check("rst_conflict_busy", 64'(bus.q_busy1), 64'(0));
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    was_rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(bus.alu_valid && !g_alu) || was_rst) begin
        bus.alu_valid = $urandom_range(0, 2) != 0;
        bus.alu_rd = 5'($urandom_range(0, 7));
        bus.alu_data = {$urandom(), $urandom()};
      end
      if (!(bus.mem_valid && !g_mem) || was_rst) begin
        bus.mem_valid = $urandom_range(0, 2) != 0;
        bus.mem_rd = 5'($urandom_range(0, 7));
        bus.mem_data = {$urandom(), $urandom()};
      end
      bus.iss_valid = $urandom_range(0, 1) != 0;
      bus.iss_rd = 5'($urandom_range(0, 7));
      bus.q_rs1 = 5'($urandom_range(0, 7));
      bus.q_rs2 = 5'($urandom_range(0, 7));
      rst = $urandom_range(0, 199) == 0;
      was_rst = rst;
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller for the 32 x 64-bit integer register file. It arbitrates the register file's single write port between the ALU and load-unit writeback sources using round-robin priority with valid/ready handshakes. It drives the file's write enable, write index and write data from registers, and optionally tracks outstanding writes per register for hazard detection in decode.

## Interface

- REG_ADDR_W, 5, register index width; the file holds 2^REG_ADDR_W entries.
- DATA_W, 64, write data width.
- CNT_W, 2, width of each per-register outstanding-write counter (scoreboard only).
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU has a result to write back.
- alu_rd  input  REG_ADDR_W  ALU destination index.
- alu_data  input  DATA_W  ALU result.
- alu_ready  output  1  ALU result accepted this cycle.
- mem_valid  input  1  load unit has data to write back.
- mem_rd  input  REG_ADDR_W  load destination index.
- mem_data  input  DATA_W  load data.
- mem_ready  output  1  load data accepted this cycle.
- rf_we  output  1  register-file write enable.
- rf_rd  output  REG_ADDR_W  register-file write index.
- rf_wdata  output  DATA_W  register-file write data.
- iss_valid  input  1  decode issues an instruction that writes iss_rd (scoreboard only).
- iss_rd  input  REG_ADDR_W  issuing destination index.
- iss_ready  output  1  issue accepted; low when the counter for iss_rd is saturated.
- q_rs1, q_rs2  input  REG_ADDR_W  decode source indices to check.
- q_busy1, q_busy2  output  1  the corresponding source has outstanding writes.

## Operation

- Arbitration state is last_grant (ALU or MEM). Reset value: MEM, so the ALU wins the first conflict.
- Only one requester valid: that requester is granted.
- Both requesters valid: the requester that is not last_grant is granted. last_grant updates only on a grant.
- The granted requester sees ready=1 combinationally in the same cycle. The loser sees ready=0 and must hold its valid, rd and data stable until accepted.
- Write with rd=0: the request is accepted (ready=1, counted as a grant for last_grant). rf_we stays 0 because x0 is hardwired to zero.
- Output registers on posedge after a grant with rd≠0: rf_we=1, rf_rd, rf_wdata. With no grant: rf_we=0; rf_rd and rf_wdata hold their previous values.
- The register file writes on negedge, so the outputs are stable for half a cycle before the write.
- Scoreboard: one CNT_W-bit counter per register. Counter 0 is hardwired to 0.
  - Accepted issue (iss_valid && iss_ready && iss_rd≠0): counter +1.
  - Granted writeback with rd≠0: counter −1.
  - Issue and writeback to the same rd in the same cycle: counter unchanged.
  - iss_ready = (counter[iss_rd] != 2^CNT_W−1). Counters never wrap.
  - A writeback to a register whose counter is 0 leaves it at 0 and does not underflow. This is a protocol error.
- q_busy1/q_busy2 are combinational from the counters: busy = (counter≠0). They do not reflect changes made in the current cycle.

## Timing

- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, last_grant=MEM, all counters=0.
- Combinational outputs during reset: alu_ready=0, mem_ready=0, iss_ready=0.
- Latency: acceptance cycle N, then rf_we=1 in cycle N+1, then the register file is written at the negedge of N+1.
- Throughput: one write per cycle. With continuous dual requests, grants alternate every cycle.
- Reset asserted mid-conflict: the pending loser is dropped by the controller. The source must re-present the request after reset.

## Configuration

- RF_SCOREBOARD_EN defined: counters, issue port and busy outputs behave as described above.
- RF_SCOREBOARD_EN undefined:
  - No counters are instantiated.
  - iss_ready is tied to 1.
  - q_busy1 and q_busy2 are tied to 0.
  - iss_valid, iss_rd, q_rs1 and q_rs2 are ignored.
  - Arbitration behaviour is identical in both configurations.

## Structure

- Shared package riscv_rf_pkg holds:
  - REG_ADDR_W and DATA_W defaults.
  - The source enum wb_src_t {WB_ALU, WB_MEM}.
  - The constant REG_ZERO=0.
- Sub-module rf_scoreboard holds the counter array, the increment/decrement logic and the busy lookup. It is instantiated only under RF_SCOREBOARD_EN.

## Test plan

- Reset, then ALU only: alu_rd=5, alu_data=0x1234 → alu_ready=1 the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234.
- Both valid for 4 cycles after reset (ALU rd=1, MEM rd=2) → grants ALU, MEM, ALU, MEM; rf_rd sequence 1, 2, 1, 2.
- mem_rd=0, mem_data=0xFF → mem_ready=1; rf_we stays 0 the next cycle.
- Scoreboard:
  - Issue rd=7 three times → q_busy1=1 with q_rs1=7.
  - Fourth issue to rd=7 → iss_ready=0.
  - Three writebacks to rd=7 → q_busy1=0.
- Scoreboard: counter[3]=1, then issue rd=3 and ALU writeback rd=3 in the same cycle → counter[3] stays 1 and busy stays 1.
- Reset asserted while MEM is waiting on a conflict → the next cycle has rf_we=0, all ready outputs 0 and all counters 0.
